block_nest_checker: RTL
=======================

BLOCK_NEST_CHECKER -- requirements
Module: block_nest_checker

Interface
REQ-001 SHALL provide parameter DEPTH_W, default 8: width of the nesting-depth counter.
REQ-002 SHALL provide parameter MAX_DEPTH, default 255: largest legal depth, with MAX_DEPTH <= 2^DEPTH_W-1.
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port clear  input  1  synchronous clear; same effect as reset, takes priority over in_valid.
REQ-006 SHALL provide port in_valid  input  1  character qualifier; in is ignored when low.
REQ-007 SHALL provide port in  input  8  ASCII character.
REQ-008 SHALL provide port result  output  1  high when the text so far is balanced and error-free.
REQ-009 SHALL provide port depth  output  DEPTH_W  committed nesting depth.
REQ-010 SHALL provide port err  output  1  sticky error: underflow or overflow occurred.

Function
REQ-011 SHALL run a word FSM with states SP, OTH, B, BE, BEG, BEGI, BEGIN, E, EN, END, advancing only on cycles with in_valid=1.
REQ-012 SHALL match letters case-insensitively; a delimiter is space (0x20); every other byte is a non-delimiter.
REQ-013 SHALL apply these transitions. Any state + delimiter -> SP. SP + b -> B, SP + e -> E, SP + other -> OTH. B+e -> BE, BE+g -> BEG, BEG+i -> BEGI, BEGI+n -> BEGIN, E+n -> EN, EN+d -> END. Any other non-delimiter -> OTH. OTH, BEGIN and END + non-delimiter -> OTH.
REQ-014 SHALL hold a pending delta P: +1 in BEGIN, -1 in END, 0 in every other state; P is combinational from the state.
REQ-015 SHALL commit on a delimiter accepted while in BEGIN or END: C <= C+P.
REQ-016 SHALL make the commit take effect on the same clock edge the delimiter is accepted; depth shows the new value the next cycle.
REQ-017 SHALL raise err and leave C unchanged when C+P < 0 at commit (underflow).
REQ-018 SHALL raise err and leave C unchanged when C+P > MAX_DEPTH at commit (overflow).
REQ-019 SHALL keep err sticky; while err=1, C is frozen and the FSM keeps running.
REQ-020 SHALL drive result = (C+P == 0) && !err, combinationally. It reflects a pending keyword immediately: "begin" not yet delimited gives result=0.
REQ-021 SHALL compute C+P at DEPTH_W+1 bits signed; no wrap-around.
REQ-022 SHALL produce no effect from consecutive delimiters or from in_valid=0 cycles.
REQ-023 SHALL NOT count a keyword whose word continues, e.g. "beginx" or "ends"; it moves to OTH and P returns to 0.
REQ-024 SHALL NOT commit a word that ends without a delimiter; it stays pending, and result still reflects P.

Reset
REQ-025 SHALL, on reset_n low and on clear, immediately set FSM=SP, C=0, err=0, giving result=1, depth=0, err=0. The reset_n effect is asynchronous; clear takes effect at the next edge.
REQ-026 SHALL discard any pending keyword on reset or clear mid-word.

Configuration
REQ-027 SHALL honour macro BLOCK_NEST_CHECKER_WS_DELIM_EN. When defined, tab (0x09), LF (0x0A) and CR (0x0D) are delimiters equivalent to space in every rule. When undefined, only 0x20 is a delimiter and those bytes are ordinary non-delimiters (-> OTH).

Verification
REQ-028 SHALL cover nesting: "begin begin end end " -> depth 1,2,1,0 after each delimiter; result=1 at the end; err=0.
REQ-029 SHALL cover pending and non-keywords: "BeGiN" with no delimiter -> result=0, depth=0. Then "x " -> result=1, depth=0.
REQ-030 SHALL cover underflow: "end " from reset -> result=0 before the space, err=1 after it, depth=0. Then "begin " -> depth stays 0, result=0.
REQ-031 SHALL cover overflow: with MAX_DEPTH=2, "begin begin begin " -> depth=2, err=1, result=0.
REQ-032 SHALL cover the handshake and reset: "begin" with in_valid=0 gaps, then clear=1 together with in_valid=1 and in=" " -> depth=0, result=1. Then asserting reset_n=0 mid-word -> outputs return to reset values without a clock edge.
REQ-033 SHALL cover the macro: "begin\tend " gives depth 1 then 0 with the macro defined, and depth 0 with result=1 (both words OTH) without it.

Source files
------------

// File: rtl/block_nest_checker.sv
// block_nest_checker: streams ASCII text and checks that begin/end keywords nest correctly.
//   Parameters: DEPTH_W (depth counter width), MAX_DEPTH (largest legal depth).
//   Ports: clk, reset_n (async active-low), clear (sync, wins over in_valid),
//          in_valid/in (character stream), result (balanced and error-free),
//          depth (committed nesting depth), err (sticky underflow/overflow).
//   Macro BLOCK_NEST_CHECKER_WS_DELIM_EN: tab, LF and CR also act as delimiters.
module block_nest_checker #(
    parameter int DEPTH_W   = 8,
    parameter int MAX_DEPTH = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               result,
    output logic [DEPTH_W-1:0] depth,
    output logic               err
);
    typedef enum logic [3:0] {
        S_SP, S_OTH, S_B, S_BE, S_BEG, S_BEGI, S_BEGIN, S_E, S_EN, S_END
    } state_t;

    localparam logic signed [DEPTH_W:0] MAX_S = (DEPTH_W+1)'(MAX_DEPTH);

    state_t                    state_q, state_d;
    logic [DEPTH_W-1:0]        c_q, c_d;
    logic                      err_q, err_d;
    logic [7:0]                lc;
    logic                      delim, commit, bad;
    logic signed [DEPTH_W:0]   p, sum;

    // Forcing bit 5 folds upper-case letters onto lower case; only 'B'/'b' map to 'b', etc.
    assign lc = in | 8'h20;

`ifdef BLOCK_NEST_CHECKER_WS_DELIM_EN
    assign delim = (in == 8'h20) || (in == 8'h09) || (in == 8'h0A) || (in == 8'h0D);
`else
    assign delim = (in == 8'h20);
`endif

    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            if (delim) state_d = S_SP;
            else begin
                case (state_q)
                    S_SP:    state_d = (lc == 8'h62) ? S_B : (lc == 8'h65) ? S_E : S_OTH;
                    S_B:     state_d = (lc == 8'h65) ? S_BE    : S_OTH;
                    S_BE:    state_d = (lc == 8'h67) ? S_BEG   : S_OTH;
                    S_BEG:   state_d = (lc == 8'h69) ? S_BEGI  : S_OTH;
                    S_BEGI:  state_d = (lc == 8'h6E) ? S_BEGIN : S_OTH;
                    S_E:     state_d = (lc == 8'h6E) ? S_EN    : S_OTH;
                    S_EN:    state_d = (lc == 8'h64) ? S_END   : S_OTH;
                    default: state_d = S_OTH;
                endcase
            end
        end
    end

    // Pending delta of a complete but not yet delimited keyword; sum is one bit wider and signed so it never wraps.
    assign p      = (state_q == S_BEGIN) ? (DEPTH_W+1)'(1) :
                    (state_q == S_END)   ? {(DEPTH_W+1){1'b1}} : '0;
    assign sum    = $signed({1'b0, c_q}) + p;
    assign bad    = sum[DEPTH_W] || (sum > MAX_S);
    assign commit = in_valid && delim && (state_q == S_BEGIN || state_q == S_END) && !err_q;
    assign c_d    = (commit && !bad) ? sum[DEPTH_W-1:0] : c_q;
    assign err_d  = err_q || (commit && bad);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_SP;
            c_q     <= '0;
            err_q   <= 1'b0;
        end else if (clear) begin
            state_q <= S_SP;
            c_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            err_q   <= err_d;
        end
    end

    assign result = (sum == '0) && !err_q;
    assign depth  = c_q;
    assign err    = err_q;
endmodule
